// File: rtl/imem_loader.sv
// Byte-stream program loader writing 16-bit big-endian words into instruction memory.
// Optional trailing XOR checksum byte is enabled with `define LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [7:0]        Byte_In,
    input  logic              Byte_Valid,
    output logic              Byte_Ready,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [15:0]       Mem_WData,
    output logic              Cpu_Hold,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_DAT_HI,
        S_DAT_LO, S_WRITE, S_CHK, S_DONE
    } state_t;

    state_t            r_state;
    logic [15:0]       r_n;
    logic [16:0]       r_cnt;
    logic [7:0]        r_hi;
    logic [7:0]        r_csum;
    logic              r_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic              r_hold;
    logic              r_done;
    logic              r_err;

    logic              w_hs;
    logic [16:0]       w_cnt_nx;
    logic [16:0]       w_hdr;

    assign w_hs     = Byte_Valid && r_ready;
    assign w_cnt_nx = r_cnt + 17'd1;
    assign w_hdr    = {1'b0, r_n[15:8], Byte_In};

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_csum  <= '0;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (Start) begin
                    r_state <= S_HDR_HI;
                    r_ready <= 1'b1;
                    r_hold  <= 1'b1;
                    r_err   <= 1'b0;
                    r_cnt   <= '0;
                    r_addr  <= '0;
                    r_csum  <= '0;
                end
                S_HDR_HI: if (w_hs) begin
                    r_n[15:8] <= Byte_In;
                    r_state   <= S_HDR_LO;
                end
                S_HDR_LO: if (w_hs) begin
                    r_n[7:0] <= Byte_In;
                    if (w_hdr > DEPTH) r_err <= 1'b1;
                    if (w_hdr == 17'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state <= S_CHK;
`else
                        r_state <= S_DONE;
                        r_ready <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_state <= S_DAT_HI;
                    end
                end
                S_DAT_HI: if (w_hs) begin
                    r_hi    <= Byte_In;
                    r_csum  <= r_csum ^ Byte_In;
                    r_state <= S_DAT_LO;
                end
                S_DAT_LO: if (w_hs) begin
                    r_wdata <= {r_hi, Byte_In};
                    r_csum  <= r_csum ^ Byte_In;
                    r_addr  <= r_cnt[ADDR_W-1:0];
                    // words past the end of memory are consumed but not written
                    r_we    <= (r_cnt < DEPTH);
                    r_ready <= 1'b0;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_cnt <= w_cnt_nx;
                    if (w_cnt_nx == {1'b0, r_n}) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state <= S_CHK;
                        r_ready <= 1'b1;
`else
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_state <= S_DAT_HI;
                        r_ready <= 1'b1;
                    end
                end
                S_CHK: if (w_hs) begin
                    if (Byte_In != r_csum) r_err <= 1'b1;
                    r_ready <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_hold  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_hold  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign Byte_Ready = r_ready;
    assign Mem_WE     = r_we;
    assign Mem_Addr   = r_addr;
    assign Mem_WData  = r_wdata;
    assign Cpu_Hold   = r_hold;
    assign Busy       = r_hold;
    assign Done       = r_done;
    assign Err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-level model of the load.
// Honours LOADER_CHECKSUM_EN when defined at compile time.
module tb_imem_loader;

    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;

    logic          Clock = 1'b0;
    logic          Reset_n;
    logic          Start;
    logic [7:0]    Byte_In;
    logic          Byte_Valid;
    logic          Byte_Ready;
    logic          Mem_WE;
    logic [AW-1:0] Mem_Addr;
    logic [15:0]   Mem_WData;
    logic          Cpu_Hold;
    logic          Busy;
    logic          Done;
    logic          Err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_data[$];
    int          wr_idx;
    int          phase;

    imem_loader #(.ADDR_W(AW)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .Byte_In    (Byte_In),
        .Byte_Valid (Byte_Valid),
        .Byte_Ready (Byte_Ready),
        .Mem_WE     (Mem_WE),
        .Mem_Addr   (Mem_Addr),
        .Mem_WData  (Mem_WData),
        .Cpu_Hold   (Cpu_Hold),
        .Busy       (Busy),
        .Done       (Done),
        .Err        (Err)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // write monitor: every Mem_WE must match the next expected word
    always @(negedge Clock) begin
        if (Reset_n && Mem_WE) begin
            if (wr_idx < exp_data.size()) begin
                chk("wr_addr", 32'(Mem_Addr), 32'(wr_idx));
                chk("wr_data", 32'(Mem_WData), 32'(exp_data[wr_idx]));
            end else begin
                chk("extra_we", 32'd1, 32'd0);
            end
            chk("rdy_in_write", 32'(Byte_Ready), 32'd0);
            wr_idx++;
        end
    end

    // mode 0: valid always, 1: toggle, 2: random with stray Start pulses
    task automatic send_byte(input logic [7:0] b, input int mode);
        int  t    = 0;
        bit  sent = 1'b0;
        while (!sent && t < 200) begin
            @(negedge Clock);
            Byte_In = b;
            phase++;
            case (mode)
                0:       Byte_Valid = 1'b1;
                1:       Byte_Valid = phase[0];
                default: Byte_Valid = ($urandom % 3) != 0;
            endcase
            Start = (mode == 2) && (($urandom % 5) == 0);
            if (Byte_Valid && Byte_Ready) begin
                sent = 1'b1;
                @(posedge Clock);
            end
            t++;
        end
        if (!sent) chk("hs_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_load(input logic [15:0] words[$], input int n,
                           input int mode, input bit bad);
        logic [7:0] cs = 8'h00;
        bit         cs_en = 1'b0;
        int         d;
        int         nw;
        bit         e_err;
`ifdef LOADER_CHECKSUM_EN
        cs_en = 1'b1;
`endif
        exp_data = {};
        wr_idx   = 0;
        for (int i = 0; i < n && i < DEPTH; i++) exp_data.push_back(words[i]);
        nw    = (n < DEPTH) ? n : DEPTH;
        e_err = (n > DEPTH) || (cs_en && bad);

        @(negedge Clock);
        Start = 1'b1; Byte_Valid = 1'b0;
        @(negedge Clock);
        Start = 1'b0;
        chk("hold_after_start", 32'(Cpu_Hold), 32'd1);
        chk("busy_after_start", 32'(Busy), 32'd1);
        chk("rdy_after_start", 32'(Byte_Ready), 32'd1);
        chk("err_cleared", 32'(Err), 32'd0);

        send_byte(8'(n >> 8), mode);
        send_byte(8'(n), mode);
        for (int i = 0; i < n; i++) begin
            send_byte(words[i][15:8], mode);
            send_byte(words[i][7:0], mode);
            cs = cs ^ words[i][15:8] ^ words[i][7:0];
        end
        if (cs_en) send_byte(bad ? (cs ^ 8'h01) : cs, mode);

        d = (n == 0 || cs_en) ? 1 : 2;
        for (int k = 1; k <= d; k++) begin
            @(negedge Clock);
            Byte_Valid = 1'b0; Start = 1'b0;
            chk("done_timing", 32'(Done), 32'(k == d));
            chk("hold_in_load", 32'(Cpu_Hold), 32'd1);
        end
        @(negedge Clock);
        chk("done_pulse", 32'(Done), 32'd0);
        chk("hold_released", 32'(Cpu_Hold), 32'd0);
        chk("busy_released", 32'(Busy), 32'd0);
        chk("rdy_idle", 32'(Byte_Ready), 32'd0);
        chk("err_final", 32'(Err), 32'(e_err));
        chk("n_writes", 32'(wr_idx), 32'(nw));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hold"}, 32'(Cpu_Hold), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_rdy"}, 32'(Byte_Ready), 32'd0);
        chk({tag, "_we"}, 32'(Mem_WE), 32'd0);
        chk({tag, "_done"}, 32'(Done), 32'd0);
        chk({tag, "_err"}, 32'(Err), 32'd0);
        chk({tag, "_addr"}, 32'(Mem_Addr), 32'd0);
        chk({tag, "_wdata"}, 32'(Mem_WData), 32'd0);
    endtask

    initial begin
        logic [15:0] w[$];
        int          n;
        Reset_n = 1'b0; Start = 1'b0; Byte_In = 8'h00; Byte_Valid = 1'b0;
        wr_idx = 0; phase = 0;
        repeat (3) @(negedge Clock);
        chk_all_zero("reset");
        Reset_n = 1'b1;

        w = {16'h1234, 16'hABCD};
        do_load(w, 2, 0, 1'b0);
        do_load(w, 2, 1, 1'b0);
        w = {};
        do_load(w, 0, 0, 1'b0);

        w = {};
        for (int i = 1; i <= DEPTH + 2; i++) w.push_back(16'(i));
        do_load(w, DEPTH + 2, 2, 1'b0);
        w = {16'h1234};
        do_load(w, 1, 0, 1'b0);
        do_load(w, 1, 0, 1'b1);

        // reset in the middle of an overflowing load
        exp_data = {16'h1122}; wr_idx = 0;
        @(negedge Clock); Start = 1'b1;
        @(negedge Clock); Start = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'(DEPTH + 2), 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge Clock);
        chk("mid_err_set", 32'(Err), 32'd1);
        #2 Reset_n = 1'b0;
        #1 chk_all_zero("midreset");
        chk("midreset_wr", 32'(wr_idx), 32'd1);
        Byte_Valid = 1'b0;
        @(negedge Clock); Reset_n = 1'b1;

        w = {16'h0BAD, 16'hF00D, 16'h5A5A};
        do_load(w, 3, 1, 1'b0);

        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(0, DEPTH + 3);
            w = {};
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            do_load(w, n, $urandom_range(0, 2), 1'($urandom % 3 == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
